adder_scoreboard_mon: RTL and testbench

//  Clocked, parametrised result checker for the N-bit adder environment. Captures operand

---
 rtl/adder_env_pkg.sv | 28 ++
 rtl/adder_scoreboard_mon_if.sv | 40 ++++
 rtl/sb_fifo.sv | 60 ++++++
 rtl/adder_scoreboard_mon.sv | 126 ++++++++++++
 tb/tb_adder_scoreboard_mon.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_env_pkg.sv
// ============================================================================
// Module : adder_env_pkg
// Brief  : Shared types and reference arithmetic for the adder check environment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package adder_env_pkg;

    localparam int c_MAX_W = 32;

    typedef enum logic [0:0] {
        CHECK  = 1'b0,
        HALTED = 1'b1
    } state_t;

    // Operands are zero-extended so the carry lands in bit c_MAX_W; callers cast down.
    function automatic logic [c_MAX_W:0] exp_sum(
        input logic [c_MAX_W-1:0] a,
        input logic [c_MAX_W-1:0] b,
        input logic               cin
    );
        return {1'b0, a} + {1'b0, b} + {{c_MAX_W{1'b0}}, cin};
    endfunction

endpackage

`default_nettype wire

// File: rtl/adder_scoreboard_mon_if.sv
// ============================================================================
// Module : adder_scoreboard_mon_if
// Brief  : Stimulus, DUT-result and status bundle of the adder scoreboard.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface adder_scoreboard_mon_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 16
);
    logic             clear;
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic [CNT_W-1:0] pass_cnt;
    logic [CNT_W-1:0] fail_cnt;
    logic             err;
    logic             ovf;
    logic             udf;
    logic [WIDTH:0]   first_exp;
    logic [WIDTH:0]   first_got;
    logic             halted;

    modport master (
        output clear, in_valid, a, b, cin, out_valid, sum, cout,
        input  pass_cnt, fail_cnt, err, ovf, udf, first_exp, first_got, halted
    );

    modport slave (
        input  clear, in_valid, a, b, cin, out_valid, sum, cout,
        output pass_cnt, fail_cnt, err, ovf, udf, first_exp, first_got, halted
    );
endinterface

`default_nettype wire

// File: rtl/sb_fifo.sv
// ============================================================================
// Module : sb_fifo
// Brief  : Expected-result queue; head is visible combinationally on dout.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sb_fifo #(
    parameter int DW    = 5,
    parameter int DEPTH = 8
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          clr,
    input  wire logic          push,
    input  wire logic          pop,
    input  wire logic [DW-1:0] din,
    output logic      [DW-1:0] dout,
    output logic               full,
    output logic               empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [DW-1:0]   r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) r_mem[r_wr_ptr] <= din;
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == (c_AW+1)'(DEPTH));
    assign empty = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/adder_scoreboard_mon.sv
// ============================================================================
// Module : adder_scoreboard_mon
// Brief  : In-order result checker for the N-bit adder with sticky error flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module adder_scoreboard_mon
    import adder_env_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 8,
    parameter int CNT_W       = 16,
    parameter int STOP_ON_ERR = 0
) (
    input wire logic              clk,
    input wire logic              rst_n,
    adder_scoreboard_mon_if.slave bus
);
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0] r_fail_cnt;
    logic             r_err;
    logic             r_ovf;
    logic             r_udf;
    logic [WIDTH:0]   r_first_exp;
    logic [WIDTH:0]   r_first_got;

    logic [WIDTH:0]   w_exp;
    logic [WIDTH:0]   w_head;
    logic [WIDTH:0]   w_got;
    logic             w_full;
    logic             w_empty;
    logic             w_active;
    logic             w_push_req;
    logic             w_pop_req;
    logic             w_push;
    logic             w_pop;
    logic             w_mismatch;
    logic             w_ovf_evt;
    logic             w_udf_evt;
    logic             w_err_evt;

    assign w_exp = (WIDTH+1)'(exp_sum(c_MAX_W'(bus.a), c_MAX_W'(bus.b), bus.cin));
    assign w_got = {bus.cout, bus.sum};

    assign w_active   = (r_state == CHECK);
    assign w_push_req = bus.in_valid  & w_active;
    assign w_pop_req  = bus.out_valid & w_active;
    assign w_pop      = w_pop_req & ~w_empty;
    // A same-cycle pop frees the slot, so a push into a full queue is still legal.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_evt  = w_push_req & w_full & ~w_pop;
    assign w_udf_evt  = w_pop_req & w_empty;
    assign w_mismatch = w_pop & (w_got != w_head);
    assign w_err_evt  = w_mismatch | w_ovf_evt | w_udf_evt;

    sb_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (bus.clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_exp),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        if (r_state == CHECK && STOP_ON_ERR != 0 && w_err_evt) begin
            w_state_nxt = HALTED;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CHECK;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else if (bus.clear) begin
            r_state     <= CHECK;
            r_pass_cnt  <= '0;
            r_fail_cnt  <= '0;
            r_err       <= 1'b0;
            r_ovf       <= 1'b0;
            r_udf       <= 1'b0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop && !w_mismatch && r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + 1'b1;
            if (w_mismatch && r_fail_cnt != '1)          r_fail_cnt <= r_fail_cnt + 1'b1;
            // fail_cnt saturates rather than wraps, so zero means no mismatch yet.
            if (w_mismatch && r_fail_cnt == '0) begin
                r_first_exp <= w_head;
                r_first_got <= w_got;
            end
            if (w_err_evt) r_err <= 1'b1;
            if (w_ovf_evt) r_ovf <= 1'b1;
            if (w_udf_evt) r_udf <= 1'b1;
        end
    end

    assign bus.pass_cnt  = r_pass_cnt;
    assign bus.fail_cnt  = r_fail_cnt;
    assign bus.err       = r_err;
    assign bus.ovf       = r_ovf;
    assign bus.udf       = r_udf;
    assign bus.first_exp = r_first_exp;
    assign bus.first_got = r_first_got;
    assign bus.halted    = (r_state == HALTED);

endmodule

`default_nettype wire

// File: tb/tb_adder_scoreboard_mon.sv
// ============================================================================
// Module : tb_adder_scoreboard_mon
// Brief  : Directed self-checking bench; three checkers share one stimulus stream.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_adder_scoreboard_mon;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    adder_scoreboard_mon_if #(.WIDTH(4), .CNT_W(16)) bus1 ();
    adder_scoreboard_mon_if #(.WIDTH(4), .CNT_W(16)) bus2 ();
    adder_scoreboard_mon_if #(.WIDTH(4), .CNT_W(2))  bus3 ();

    // bus2 (stop-on-error) and bus3 (2-bit counters) mirror bus1 stimulus.
    assign bus2.clear = bus1.clear;  assign bus3.clear = bus1.clear;
    assign bus2.in_valid = bus1.in_valid;  assign bus3.in_valid = bus1.in_valid;
    assign bus2.a = bus1.a;  assign bus3.a = bus1.a;
    assign bus2.b = bus1.b;  assign bus3.b = bus1.b;
    assign bus2.cin = bus1.cin;  assign bus3.cin = bus1.cin;
    assign bus2.out_valid = bus1.out_valid;  assign bus3.out_valid = bus1.out_valid;
    assign bus2.sum = bus1.sum;  assign bus3.sum = bus1.sum;
    assign bus2.cout = bus1.cout;  assign bus3.cout = bus1.cout;

    adder_scoreboard_mon #(.WIDTH(4), .DEPTH(8), .CNT_W(16), .STOP_ON_ERR(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1));
    adder_scoreboard_mon #(.WIDTH(4), .DEPTH(8), .CNT_W(16), .STOP_ON_ERR(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .bus(bus2));
    adder_scoreboard_mon #(.WIDTH(4), .DEPTH(8), .CNT_W(2), .STOP_ON_ERR(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus1.clear = 1'b0; bus1.in_valid = 1'b0; bus1.out_valid = 1'b0;
        bus1.a = '0; bus1.b = '0; bus1.cin = 1'b0; bus1.sum = '0; bus1.cout = 1'b0;
    endtask

    task automatic set_push(input logic [3:0] a, input logic [3:0] b, input logic cin);
        bus1.in_valid = 1'b1; bus1.a = a; bus1.b = b; bus1.cin = cin;
    endtask

    task automatic set_pop(input logic cout, input logic [3:0] sum);
        bus1.out_valid = 1'b1; bus1.cout = cout; bus1.sum = sum;
    endtask

    task automatic cyc_push(input logic [3:0] a, input logic [3:0] b, input logic cin);
        idle(); set_push(a, b, cin); step(); idle();
    endtask

    task automatic cyc_pop(input logic cout, input logic [3:0] sum);
        idle(); set_pop(cout, sum); step(); idle();
    endtask

    task automatic do_clear();
        idle(); bus1.clear = 1'b1; step(); idle();
    endtask

    task automatic test_reset();
        logic [45:0] all1;
        idle();
        rst_n = 1'b0;
        step(); step();
        all1 = {bus1.pass_cnt, bus1.fail_cnt, bus1.err, bus1.ovf, bus1.udf,
                bus1.first_exp, bus1.first_got, bus1.halted};
        n_chk++;
        if (all1 !== '0) begin $display("FAIL reset_state: got %h want 0", all1); n_fail++; end
        rst_n = 1'b1;
        step();
        cyc_push(4'd1, 4'd2, 1'b0);
        cyc_push(4'd3, 4'd3, 1'b0);
        cyc_pop(1'b0, 4'd0);
        n_chk++;
        if (bus1.err !== 1'b1 || bus1.fail_cnt !== 16'd1) begin
            $display("FAIL reset_pre_err: got err=%b fail=%0d want err=1 fail=1", bus1.err, bus1.fail_cnt); n_fail++;
        end
        // Reset asserted between edges while a push is presented.
        set_push(4'd7, 4'd7, 1'b1);
        rst_n = 1'b0;
        #2;
        all1 = {bus1.pass_cnt, bus1.fail_cnt, bus1.err, bus1.ovf, bus1.udf,
                bus1.first_exp, bus1.first_got, bus1.halted};
        n_chk++;
        if (all1 !== '0) begin $display("FAIL reset_async: got %h want 0", all1); n_fail++; end
        step();
        idle();
        rst_n = 1'b1;
        step();
        cyc_push(4'd1, 4'd2, 1'b0);
        cyc_pop(1'b0, 4'd3);
        n_chk++;
        if (bus1.pass_cnt !== 16'd1 || bus1.fail_cnt !== 16'd0 || bus1.err !== 1'b0 || bus1.udf !== 1'b0) begin
            $display("FAIL reset_clean: got pass=%0d fail=%0d err=%b udf=%b want 1 0 0 0",
                     bus1.pass_cnt, bus1.fail_cnt, bus1.err, bus1.udf); n_fail++;
        end
    endtask

    task automatic test_latency1();
        do_clear();
        n_chk++;
        if (bus1.pass_cnt !== 16'd0 || bus1.err !== 1'b0) begin
            $display("FAIL clear_state: got pass=%0d err=%b want 0 0", bus1.pass_cnt, bus1.err); n_fail++;
        end
        cyc_push(4'd3, 4'd4, 1'b0);
        cyc_pop(1'b0, 4'd7);
        n_chk++;
        if (bus1.pass_cnt !== 16'd1 || bus1.err !== 1'b0) begin
            $display("FAIL lat1_first: got pass=%0d err=%b want 1 0", bus1.pass_cnt, bus1.err); n_fail++;
        end
        cyc_push(4'd15, 4'd1, 1'b1);
        cyc_pop(1'b1, 4'b0001);
        n_chk++;
        if (bus1.pass_cnt !== 16'd2 || bus1.fail_cnt !== 16'd0) begin
            $display("FAIL lat1_carry: got pass=%0d fail=%0d want 2 0", bus1.pass_cnt, bus1.fail_cnt); n_fail++;
        end
    endtask

    task automatic test_mismatch();
        do_clear();
        cyc_push(4'd5, 4'd5, 1'b0);
        cyc_pop(1'b0, 4'd11);
        n_chk++;
        if (bus1.fail_cnt !== 16'd1 || bus1.err !== 1'b1 || bus1.pass_cnt !== 16'd0) begin
            $display("FAIL mism_count: got fail=%0d err=%b pass=%0d want 1 1 0",
                     bus1.fail_cnt, bus1.err, bus1.pass_cnt); n_fail++;
        end
        n_chk++;
        if (bus1.first_exp !== 5'b01010 || bus1.first_got !== 5'b01011) begin
            $display("FAIL mism_first: got exp=%b got=%b want 01010 01011", bus1.first_exp, bus1.first_got); n_fail++;
        end
        cyc_push(4'd2, 4'd3, 1'b1);
        cyc_pop(1'b0, 4'd7);
        n_chk++;
        if (bus1.fail_cnt !== 16'd2 || bus1.first_exp !== 5'b01010 || bus1.first_got !== 5'b01011) begin
            $display("FAIL mism_second: got fail=%0d exp=%b got=%b want 2 01010 01011",
                     bus1.fail_cnt, bus1.first_exp, bus1.first_got); n_fail++;
        end
    endtask

    task automatic test_var_latency();
        logic [3:0] va [10];
        logic [3:0] vb [10];
        logic       vc [10];
        logic [4:0] ve [10];
        for (int i = 0; i < 10; i++) begin
            va[i] = 4'(i);
            vb[i] = 4'((3 * i) % 16);
            vc[i] = 1'(i % 2);
            ve[i] = 5'(va[i]) + 5'(vb[i]) + 5'(vc[i]);
        end
        do_clear();
        for (int i = 0; i < 8; i++) cyc_push(va[i], vb[i], vc[i]);
        for (int i = 8; i < 10; i++) begin
            idle();
            set_push(va[i], vb[i], vc[i]);
            set_pop(ve[i-8][4], ve[i-8][3:0]);
            step();
        end
        idle();
        n_chk++;
        if (bus1.ovf !== 1'b0 || bus1.err !== 1'b0 || bus1.pass_cnt !== 16'd2) begin
            $display("FAIL full_pushpop: got ovf=%b err=%b pass=%0d want 0 0 2",
                     bus1.ovf, bus1.err, bus1.pass_cnt); n_fail++;
        end
        for (int i = 2; i < 10; i++) cyc_pop(ve[i][4], ve[i][3:0]);
        n_chk++;
        if (bus1.pass_cnt !== 16'd10 || bus1.fail_cnt !== 16'd0 || bus1.udf !== 1'b0) begin
            $display("FAIL varlat_order: got pass=%0d fail=%0d udf=%b want 10 0 0",
                     bus1.pass_cnt, bus1.fail_cnt, bus1.udf); n_fail++;
        end
        for (int i = 0; i < 9; i++) cyc_push(va[i], vb[i], vc[i]);
        n_chk++;
        if (bus1.ovf !== 1'b1 || bus1.err !== 1'b1 || bus1.pass_cnt !== 16'd10) begin
            $display("FAIL overflow: got ovf=%b err=%b pass=%0d want 1 1 10",
                     bus1.ovf, bus1.err, bus1.pass_cnt); n_fail++;
        end
        for (int i = 0; i < 8; i++) cyc_pop(ve[i][4], ve[i][3:0]);
        n_chk++;
        if (bus1.pass_cnt !== 16'd18 || bus1.fail_cnt !== 16'd0 || bus1.udf !== 1'b0) begin
            $display("FAIL ovf_drain: got pass=%0d fail=%0d udf=%b want 18 0 0",
                     bus1.pass_cnt, bus1.fail_cnt, bus1.udf); n_fail++;
        end
        cyc_pop(1'b0, 4'd0);
        n_chk++;
        if (bus1.udf !== 1'b1 || bus1.pass_cnt !== 16'd18) begin
            $display("FAIL ovf_dropped: got udf=%b pass=%0d want 1 18", bus1.udf, bus1.pass_cnt); n_fail++;
        end
    endtask

    task automatic test_underflow();
        do_clear();
        cyc_pop(1'b0, 4'd0);
        n_chk++;
        if (bus1.udf !== 1'b1 || bus1.err !== 1'b1 || bus1.pass_cnt !== 16'd0 ||
            bus1.fail_cnt !== 16'd0 || bus1.ovf !== 1'b0) begin
            $display("FAIL underflow: got udf=%b err=%b pass=%0d fail=%0d ovf=%b want 1 1 0 0 0",
                     bus1.udf, bus1.err, bus1.pass_cnt, bus1.fail_cnt, bus1.ovf); n_fail++;
        end
        do_clear();
        idle();
        set_push(4'd2, 4'd2, 1'b0);
        set_pop(1'b0, 4'd4);
        step();
        idle();
        n_chk++;
        if (bus1.udf !== 1'b1 || bus1.pass_cnt !== 16'd0) begin
            $display("FAIL udf_samecyc: got udf=%b pass=%0d want 1 0", bus1.udf, bus1.pass_cnt); n_fail++;
        end
        cyc_pop(1'b0, 4'd4);
        n_chk++;
        if (bus1.pass_cnt !== 16'd1 || bus1.fail_cnt !== 16'd0) begin
            $display("FAIL udf_push_kept: got pass=%0d fail=%0d want 1 0", bus1.pass_cnt, bus1.fail_cnt); n_fail++;
        end
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 5; i++) begin
            cyc_push(4'd6, 4'd9, 1'b1);
            cyc_pop(1'b1, 4'd0);
        end
        n_chk++;
        if (bus3.pass_cnt !== 2'd3 || bus1.pass_cnt !== 16'd5) begin
            $display("FAIL sat_pass: got small=%0d wide=%0d want 3 5", bus3.pass_cnt, bus1.pass_cnt); n_fail++;
        end
        for (int i = 0; i < 4; i++) begin
            cyc_push(4'd1, 4'd1, 1'b0);
            cyc_pop(1'b0, 4'd3);
        end
        n_chk++;
        if (bus3.fail_cnt !== 2'd3 || bus3.first_exp !== 5'b00010 || bus1.fail_cnt !== 16'd4) begin
            $display("FAIL sat_fail: got small=%0d first=%b wide=%0d want 3 00010 4",
                     bus3.fail_cnt, bus3.first_exp, bus1.fail_cnt); n_fail++;
        end
    endtask

    task automatic test_stop_on_err();
        do_clear();
        n_chk++;
        if (bus2.halted !== 1'b0 || bus2.err !== 1'b0) begin
            $display("FAIL stop_clear0: got halted=%b err=%b want 0 0", bus2.halted, bus2.err); n_fail++;
        end
        cyc_push(4'd5, 4'd5, 1'b0);
        cyc_pop(1'b0, 4'd11);
        n_chk++;
        if (bus2.halted !== 1'b1 || bus2.err !== 1'b1 || bus2.fail_cnt !== 16'd1 || bus1.halted !== 1'b0) begin
            $display("FAIL stop_halt: got halted=%b err=%b fail=%0d other_halted=%b want 1 1 1 0",
                     bus2.halted, bus2.err, bus2.fail_cnt, bus1.halted); n_fail++;
        end
        cyc_push(4'd1, 4'd1, 1'b0);
        cyc_pop(1'b0, 4'd2);
        cyc_pop(1'b0, 4'd9);
        n_chk++;
        if (bus2.pass_cnt !== 16'd0 || bus2.fail_cnt !== 16'd1 || bus2.udf !== 1'b0 || bus1.pass_cnt !== 16'd1) begin
            $display("FAIL stop_ignore: got pass=%0d fail=%0d udf=%b other_pass=%0d want 0 1 0 1",
                     bus2.pass_cnt, bus2.fail_cnt, bus2.udf, bus1.pass_cnt); n_fail++;
        end
        do_clear();
        n_chk++;
        if ({bus2.pass_cnt, bus2.fail_cnt, bus2.err, bus2.ovf, bus2.udf,
             bus2.first_exp, bus2.first_got, bus2.halted} !== 46'd0) begin
            $display("FAIL stop_clear: got halted=%b err=%b fail=%0d first_exp=%b want all 0",
                     bus2.halted, bus2.err, bus2.fail_cnt, bus2.first_exp); n_fail++;
        end
        cyc_push(4'd1, 4'd2, 1'b0);
        cyc_pop(1'b0, 4'd3);
        n_chk++;
        if (bus2.pass_cnt !== 16'd1 || bus2.halted !== 1'b0) begin
            $display("FAIL stop_resume: got pass=%0d halted=%b want 1 0", bus2.pass_cnt, bus2.halted); n_fail++;
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle();
        test_reset();
        test_latency1();
        test_mismatch();
        test_var_latency();
        test_underflow();
        test_saturation();
        test_stop_on_err();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
